sec_imul_iterative: RTL and testbench
=====================================

// Module: sec_imul_iterative
// PURPOSE
//  Iterative shift-add integer multiplier sitting directly downstream of the adder/shifter primitives;
//  it is the first sequential consumer of vc_SimpleAdder and the logical shifters.
//  Accepts an operand pair over a val/rdy request port and returns the low p_nbits bits of the product
//  over a val/rdy response port.
//  Every data register carries the {Data domain} label of the domain captured when the request is accepted.
// PARAMETERS
//  p_nbits   32   operand/result width (>=2)
//  p_cnt_w   clog2(p_nbits)+1   iteration counter width, derived, not overridden
// PORTS
//  clk          in   1        clock, all state updates on rising edge
//  reset        in   1        asynchronous, active-high; clears all state immediately
//  req_domain   in   1        {L} security domain of the incoming request (0 = normal, 1 = secure)
//  req_val      in   1        {L} request valid
//  req_rdy      out  1        {L} request ready
//  req_a        in   p_nbits  {Data req_domain} multiplicand
//  req_b        in   p_nbits  {Data req_domain} multiplier
//  resp_val     out  1        {L} response valid
//  resp_rdy     in   1        {L} response ready
//  resp_domain  out  1        {L} domain latched at acceptance
//  resp_result  out  p_nbits  {Data resp_domain} low p_nbits bits of req_a*req_b
// BEHAVIOUR
//  Reset values: req_rdy=0 while reset is high, 1 in the first IDLE cycle after release.
//   resp_val=0; resp_domain=0; resp_result=0; counter=0.
//  FSM states: IDLE, CALC, DONE.
//   IDLE: req_rdy=1, resp_val=0. On req_val&req_rdy: a_reg<=req_a, b_reg<=req_b, res<=0,
//    domain_reg<=req_domain, cnt<=0, go to CALC.
//   CALC: req_rdy=0, resp_val=0. Each cycle: if b_reg[0], res<=res+a_reg (carry discarded, mod 2^p_nbits).
//    Also a_reg<=a_reg<<1, b_reg<=b_reg>>1, cnt<=cnt+1. When cnt==p_nbits-1, go to DONE.
//    No early termination: fixed latency, so timing is independent of data (no secure-data timing channel).
//   DONE: resp_val=1, resp_result=res, resp_domain=domain_reg. On resp_rdy go to IDLE.
//    Otherwise hold all outputs stable, indefinitely.
//  Latency: accept edge to resp_val high is exactly p_nbits+1 cycles; one request in flight at most.
//   Throughput is 1 per p_nbits+2 cycles with resp_rdy held high.
//  Handshakes: transfer occurs only on val&rdy in the same cycle.
//   req_rdy never depends combinationally on req_val.
//   resp_val never drops without resp_rdy.
//  Security rules:
//   domain_reg changes only in IDLE on acceptance.
//   On DONE->IDLE, res, a_reg and b_reg are zeroed, so no secure residue is visible to a later normal request.
//   Control signals (state, cnt, val/rdy) are {L} and depend only on {L} inputs.
//  Boundaries:
//   Operands 0 or 1 behave normally, still full latency.
//   Overflow wraps silently (low bits only).
//   req_val while busy is ignored (req_rdy=0).
//   reset asserted mid-CALC or mid-DONE aborts the operation with no response, returning to reset values asynchronously.
//   X on req_a/req_b when req_val=0 must not propagate to any output.
// STRUCTURE
//  Shared header vc-imul-msgs.v: `define state encodings (IMUL_IDLE=2'd0, IMUL_CALC=2'd1, IMUL_DONE=2'd2)
//   and the domain encodings (DOMAIN_NORMAL=1'b0, DOMAIN_SECURE=1'b1).
//  One natural sub-module: sec_imul_iterative_dpath.
//   Holds a/b/res/domain registers and instantiates vc_SimpleAdder, vc_LeftLogicalShifter,
//    vc_RightLogicalShifter, all with domain=domain_reg.
//   Exports b_lsb to the control.
//  The FSM and counter live in the top level and drive the dpath enables/muxes.
// TESTING
//  3 x 4, domain 0, resp_rdy=1 -> resp_result=12, resp_domain=0, resp_val exactly p_nbits+1 cycles after accept.
//  0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001 (wraparound); 0 x 0xDEADBEEF -> 0 with identical latency.
//  Secure request 7 x 6, resp_rdy low 10 cycles -> resp_val, result 42 and domain 1 held stable;
//   req_rdy=0 throughout; after the handshake, a normal request 2 x 2 -> 4, domain 0.
//  Assert reset mid-CALC (cycle 5), release, issue 5 x 5 -> no stale response; resp_val=0 during reset; result 25.
//  Back-to-back with random req_val/resp_rdy over 1000 random operand pairs -> matches golden model (a*b) mod 2^32,
//   in order, no drops or duplicates.

Source files
------------

// File: rtl/sec_imul_iterative_pkg.sv
// sec_imul_iterative_pkg: shared state and domain encodings for the iterative multiplier
package sec_imul_iterative_pkg;
  typedef enum logic [1:0] {
    IMUL_IDLE = 2'd0,
    IMUL_CALC = 2'd1,
    IMUL_DONE = 2'd2
  } imul_state_e;
  localparam logic DOMAIN_NORMAL = 1'b0;
  localparam logic DOMAIN_SECURE = 1'b1;
endpackage

// File: rtl/sec_imul_iterative_dpath.sv
// sec_imul_iterative_dpath: operand, partial-product and domain registers for the shift-add multiplier
module sec_imul_iterative_dpath
  import sec_imul_iterative_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               add_en,
  input  logic               clear,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  input  logic               req_domain,
  output logic               b_lsb,
  output logic [p_nbits-1:0] result,
  output logic               domain
);
  logic [p_nbits-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [p_nbits-1:0] a_shl, b_shr, sum;
  logic               dom_q, dom_d;

  vc_SimpleAdder #(.p_nbits(p_nbits)) u_add (
    .in0 (res_q),
    .in1 (a_q),
    .out (sum)
  );

  vc_LeftLogicalShifter #(.p_nbits(p_nbits), .p_shamt_nbits(1)) u_shl (
    .in    (a_q),
    .shamt (1'b1),
    .out   (a_shl)
  );

  vc_RightLogicalShifter #(.p_nbits(p_nbits), .p_shamt_nbits(1)) u_shr (
    .in    (b_q),
    .shamt (1'b1),
    .out   (b_shr)
  );

  // Operands are only sampled on acceptance; completion wipes data so no residue survives into IDLE
  always_comb begin
    a_d   = load ? req_a : clear ? '0 : step ? a_shl : a_q;
    b_d   = load ? req_b : clear ? '0 : step ? b_shr : b_q;
    res_d = (load || clear) ? '0 : add_en ? sum : res_q;
    dom_d = load ? req_domain : dom_q;
  end

  // Data and domain registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      dom_q <= DOMAIN_NORMAL;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      dom_q <= dom_d;
    end
  end

  assign b_lsb  = b_q[0];
  assign result = res_q;
  assign domain = dom_q;
endmodule

// File: rtl/vc_LeftLogicalShifter.sv
// vc_LeftLogicalShifter: logical left shift by shamt, zero fill
module vc_LeftLogicalShifter #(
  parameter int p_nbits       = 32,
  parameter int p_shamt_nbits = 1
) (
  input  logic [p_nbits-1:0]       in,
  input  logic [p_shamt_nbits-1:0] shamt,
  output logic [p_nbits-1:0]       out
);
  assign out = in << shamt;
endmodule

// File: rtl/vc_RightLogicalShifter.sv
// vc_RightLogicalShifter: logical right shift by shamt, zero fill
module vc_RightLogicalShifter #(
  parameter int p_nbits       = 32,
  parameter int p_shamt_nbits = 1
) (
  input  logic [p_nbits-1:0]       in,
  input  logic [p_shamt_nbits-1:0] shamt,
  output logic [p_nbits-1:0]       out
);
  assign out = in >> shamt;
endmodule

// File: rtl/vc_SimpleAdder.sv
// vc_SimpleAdder: modular adder, carry out discarded
module vc_SimpleAdder #(
  parameter int p_nbits = 32
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  output logic [p_nbits-1:0] out
);
  assign out = in0 + in1;
endmodule

// File: rtl/sec_imul_iterative.sv
// sec_imul_iterative: fixed-latency shift-add multiplier with val/rdy ports and domain tagging
module sec_imul_iterative
  import sec_imul_iterative_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_domain,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic               resp_domain,
  output logic [p_nbits-1:0] resp_result
);
  localparam int p_cnt_w = $clog2(p_nbits) + 1;
  localparam logic [p_cnt_w-1:0] CNT_LAST = p_cnt_w'(p_nbits - 1);

  imul_state_e        state_q, state_d;
  logic [p_cnt_w-1:0] cnt_q, cnt_d;
  logic               req_rdy_q, req_rdy_d, resp_val_q, resp_val_d;
  logic               load, step, add_en, clear, last, b_lsb;

  // Next-state logic; the counter runs all p_nbits steps regardless of operand values
  always_comb begin
    load       = (state_q == IMUL_IDLE) && req_val && req_rdy_q;
    step       = state_q == IMUL_CALC;
    add_en     = step && b_lsb;
    last       = step && (cnt_q == CNT_LAST);
    clear      = (state_q == IMUL_DONE) && resp_rdy;
    state_d    = load ? IMUL_CALC : last ? IMUL_DONE : clear ? IMUL_IDLE : state_q;
    cnt_d      = load ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    req_rdy_d  = state_d == IMUL_IDLE;
    resp_val_d = state_d == IMUL_DONE;
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IMUL_IDLE;
      cnt_q      <= '0;
      req_rdy_q  <= 1'b0;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_rdy_q  <= req_rdy_d;
      resp_val_q <= resp_val_d;
    end
  end

  sec_imul_iterative_dpath #(.p_nbits(p_nbits)) u_dpath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .add_en     (add_en),
    .clear      (clear),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_domain (req_domain),
    .b_lsb      (b_lsb),
    .result     (resp_result),
    .domain     (resp_domain)
  );

  assign req_rdy  = req_rdy_q;
  assign resp_val = resp_val_q;
endmodule

// File: tb/tb_sec_imul_iterative.sv
// tb_sec_imul_iterative: directed and randomized checks of the iterative multiplier
module tb_sec_imul_iterative;
  logic        clk, reset, req_domain, req_val, req_rdy, resp_val, resp_rdy, resp_domain;
  logic [31:0] req_a, req_b, resp_result;
  int          vectors = 0;
  int          miscompares = 0;
  int          lat;
  logic [31:0] ra, rb;
  logic        rd;

  sec_imul_iterative #(.p_nbits(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_domain  (req_domain),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_domain (resp_domain),
    .resp_result (resp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for acceptance, then park the data inputs at X
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic d);
    int n = 0;
    req_a = a;
    req_b = b;
    req_domain = d;
    req_val = 1'b1;
    while (req_rdy !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("accept_timeout", 32'(n < 100), 32'd1);
    tick();
    req_val = 1'b0;
    req_a = 'x;
    req_b = 'x;
    req_domain = 1'b0;
  endtask

  // Edges from the accept edge (counted as 1) through the edge that raises resp_val
  task automatic wait_resp(output int l);
    l = 1;
    while (resp_val !== 1'b1 && l < 200) begin
      tick();
      l++;
    end
  endtask

  initial begin
    reset = 1'b1;
    req_val = 1'b0;
    resp_rdy = 1'b0;
    req_domain = 1'b0;
    req_a = 'x;
    req_b = 'x;
    tick();
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_resp_dom", 32'(resp_domain), 32'd0);
    chk("rst_result", resp_result, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_req_rdy", 32'(req_rdy), 32'd1);
    chk("idle_resp_val", 32'(resp_val), 32'd0);

    resp_rdy = 1'b1;
    issue(32'd3, 32'd4, 1'b0);
    wait_resp(lat);
    chk("3x4_lat", lat, 32'd33);
    chk("3x4_res", resp_result, 32'd12);
    chk("3x4_dom", 32'(resp_domain), 32'd0);
    tick();
    chk("3x4_single", 32'(resp_val), 32'd0);
    chk("3x4_zeroed", resp_result, 32'd0);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_resp(lat);
    chk("wrap_lat", lat, 32'd33);
    chk("wrap_res", resp_result, 32'h0000_0001);
    tick();

    issue(32'd0, 32'hDEAD_BEEF, 1'b0);
    wait_resp(lat);
    chk("zero_lat", lat, 32'd33);
    chk("zero_res", resp_result, 32'd0);
    tick();

    issue(32'd1, 32'h1234_5678, 1'b0);
    wait_resp(lat);
    chk("one_lat", lat, 32'd33);
    chk("one_res", resp_result, 32'h1234_5678);
    tick();

    resp_rdy = 1'b0;
    issue(32'd7, 32'd6, 1'b1);
    wait_resp(lat);
    chk("sec_lat", lat, 32'd33);
    req_val = 1'b1;
    req_a = 32'd9;
    req_b = 32'd9;
    for (int i = 0; i < 10; i++) begin
      chk("hold_val", 32'(resp_val), 32'd1);
      chk("hold_res", resp_result, 32'd42);
      chk("hold_dom", 32'(resp_domain), 32'd1);
      chk("hold_req_rdy", 32'(req_rdy), 32'd0);
      tick();
    end
    req_val = 1'b0;
    req_a = 'x;
    req_b = 'x;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    chk("sec_drop", 32'(resp_val), 32'd0);
    chk("sec_residue", resp_result, 32'd0);
    resp_rdy = 1'b1;
    issue(32'd2, 32'd2, 1'b0);
    wait_resp(lat);
    chk("2x2_lat", lat, 32'd33);
    chk("2x2_res", resp_result, 32'd4);
    chk("2x2_dom", 32'(resp_domain), 32'd0);
    tick();

    issue(32'd9, 32'd9, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    chk("abort_val", 32'(resp_val), 32'd0);
    chk("abort_rdy", 32'(req_rdy), 32'd0);
    chk("abort_res", resp_result, 32'd0);
    chk("abort_dom", 32'(resp_domain), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_abort_val", 32'(resp_val), 32'd0);
    issue(32'd5, 32'd5, 1'b0);
    wait_resp(lat);
    chk("5x5_lat", lat, 32'd33);
    chk("5x5_res", resp_result, 32'd25);
    chk("5x5_dom", 32'(resp_domain), 32'd0);
    tick();

    resp_rdy = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rd = 1'($urandom_range(0, 1));
      for (int j = $urandom_range(0, 2); j > 0; j--) tick();
      issue(ra, rb, rd);
      wait_resp(lat);
      for (int j = $urandom_range(0, 3); j > 0; j--) tick();
      chk("rnd_val", 32'(resp_val), 32'd1);
      chk("rnd_res", resp_result, ra * rb);
      chk("rnd_dom", 32'(resp_domain), 32'(rd));
      resp_rdy = 1'b1;
      tick();
      resp_rdy = 1'b0;
      chk("rnd_single", 32'(resp_val), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
